// File: rtl/aes_io_pkg.sv
// Shared types and constants for the AES byte-serial front/back end.
package aes_io_pkg;

    typedef enum logic [1:0] {
        LOAD_PT  = 2'd0,
        LOAD_KEY = 2'd1,
        RUN      = 2'd2,
        UNLOAD   = 2'd3
    } state_t;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_CNT_W  = 4;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BLOCK_BYTES - 1);

    // Shift register instance indices: plaintext, key, ciphertext.
    localparam int NUM_SR = 3;
    localparam int SR_PT  = 0;
    localparam int SR_KEY = 1;
    localparam int SR_CT  = 2;

endpackage

// File: rtl/aes_byte_shreg.sv
// 128-bit register with parallel load and MSB-first byte shift (in at [7:0], out at [127:120]).
module aes_byte_shreg (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [127:0] i_load_data,
    input  logic         i_shift,
    input  logic [7:0]   i_byte,
    output logic [127:0] o_q,
    output logic [7:0]   o_byte
);

    logic [127:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= {r_q[119:0], i_byte};
        end
    end

    assign o_q    = r_q;
    assign o_byte = r_q[127:120];

endmodule

// File: rtl/aes_byte_io.sv
// Byte-serial wrapper around the iterative AES-128 core: gathers plaintext and key,
// runs the core under a watchdog, then streams the ciphertext out.
module aes_byte_io
    import aes_io_pkg::*;
#(
    parameter int MAX_RUN_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         core_rst,
    output logic [127:0] core_din,
    output logic [127:0] core_key,
    input  logic [127:0] core_dout,
    input  logic         core_done,
    output logic         busy,
    output logic         err
);

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MAX_RUN_CYCLES - 1);

    state_t                r_state, w_state_next;
    logic [BYTE_CNT_W-1:0] r_cnt, w_cnt_next;
    logic [CNT_W-1:0]      r_wdog, w_wdog_next;
    logic                  r_core_rst, w_core_rst_next;
    logic                  r_err, w_err_next;
    logic                  w_in_xfer, w_out_xfer;

    logic [NUM_SR-1:0]     w_load, w_shift;
    logic [127:0]          w_load_data [NUM_SR];
    logic [7:0]            w_shin      [NUM_SR];
    logic [127:0]          w_q         [NUM_SR];
    logic [7:0]            w_byte      [NUM_SR];

    assign in_ready   = (r_state == LOAD_PT) || (r_state == LOAD_KEY);
    assign out_valid  = (r_state == UNLOAD);
    assign busy       = (r_state == RUN) || (r_state == UNLOAD);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Only the ciphertext register is ever parallel-loaded; only the input ones take bytes.
    assign w_load_data[SR_PT]  = '0;
    assign w_load_data[SR_KEY] = '0;
    assign w_load_data[SR_CT]  = core_dout;
    assign w_shin[SR_PT]       = in_data;
    assign w_shin[SR_KEY]      = in_data;
    assign w_shin[SR_CT]       = 8'h00;

    generate
        for (genvar gi = 0; gi < NUM_SR; gi++) begin : g_sr
            aes_byte_shreg u_sr (
                .clk         (clk),
                .rst         (rst),
                .i_load      (w_load[gi]),
                .i_load_data (w_load_data[gi]),
                .i_shift     (w_shift[gi]),
                .i_byte      (w_shin[gi]),
                .o_q         (w_q[gi]),
                .o_byte      (w_byte[gi])
            );
        end
    endgenerate

    assign core_din = w_q[SR_PT];
    assign core_key = w_q[SR_KEY];
    assign out_data = w_byte[SR_CT];
    assign core_rst = r_core_rst;
    assign err      = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= LOAD_PT;
            r_cnt      <= '0;
            r_wdog     <= '0;
            r_core_rst <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_wdog     <= w_wdog_next;
            r_core_rst <= w_core_rst_next;
            r_err      <= w_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_wdog_next     = r_wdog;
        w_core_rst_next = r_core_rst;
        w_err_next      = r_err;
        w_load          = '0;
        w_shift         = '0;
        case (r_state)
            LOAD_PT: begin
                if (w_in_xfer) begin
                    w_shift[SR_PT] = 1'b1;
                    w_cnt_next     = r_cnt + 1'b1;
                    if (r_cnt == LAST_BYTE) w_state_next = LOAD_KEY;
                end
            end
            LOAD_KEY: begin
                if (w_in_xfer) begin
                    w_shift[SR_KEY] = 1'b1;
                    w_cnt_next      = r_cnt + 1'b1;
                    if (r_cnt == LAST_BYTE) begin
                        w_state_next    = RUN;
                        w_core_rst_next = 1'b0;
                    end
                end
            end
            RUN: begin
                w_wdog_next = r_wdog + 1'b1;
                // A done arriving in the expiry cycle still yields a valid result.
                if (core_done) begin
                    w_load[SR_CT]   = 1'b1;
                    w_core_rst_next = 1'b1;
                    w_wdog_next     = '0;
                    w_state_next    = UNLOAD;
                end else if (r_wdog == WDOG_LAST) begin
                    w_err_next      = 1'b1;
                    w_core_rst_next = 1'b1;
                    w_wdog_next     = '0;
                    w_state_next    = LOAD_PT;
                end
            end
            UNLOAD: begin
                if (w_out_xfer) begin
                    w_shift[SR_CT] = 1'b1;
                    w_cnt_next     = r_cnt + 1'b1;
                    if (r_cnt == LAST_BYTE) w_state_next = LOAD_PT;
                end
            end
            default: w_state_next = LOAD_PT;
        endcase
    end

endmodule

// File: tb/tb_aes_byte_io.sv
// Self-checking bench for aes_byte_io: a stand-in AES core plus a transaction-level
// model of the byte streams compared against the DUT every cycle.
module tb_aes_byte_io;

    localparam int MAXR = 1023;

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         out_ready = 1'b0;
    logic         core_done = 1'b0;
    logic [127:0] core_dout = '0;
    logic         in_ready, out_valid, core_rst, busy, err;
    logic [7:0]   out_data;
    logic [127:0] core_din, core_key;

    aes_byte_io #(.MAX_RUN_CYCLES(MAXR), .CNT_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .core_rst  (core_rst),
        .core_din  (core_din),
        .core_key  (core_key),
        .core_dout (core_dout),
        .core_done (core_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s timed out t=%0t", name, $time);
    endtask

    // Stand-in core: FIPS-197 answers for the known vectors, an arbitrary mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == C1_PT && key == C1_KEY) return C1_CT;
        if (pt == B_PT && key == B_KEY) return B_CT;
        return {pt[119:0], pt[127:120]} ^ key ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0;
    endfunction

    int done_at   = 55;   // RUN cycle in which the core raises done; -1 = never
    int ready_pct = 100;
    int run_cyc   = 0;

    // Transaction-level model: 0 = loading, 1 = core running, 2 = unloading.
    int           m_phase, m_nin, m_run, m_nout;
    logic         m_err;
    logic [127:0] m_pt, m_key, m_ct;
    logic [7:0]   rx[$];
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_data = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0; m_nin = 0; m_run = 0; m_nout = 0; m_err = 1'b0;
            m_pt = '0; m_key = '0; m_ct = '0;
            core_done = 1'b0; run_cyc = 0; prev_stall = 1'b0;
        end else begin
            if (!core_rst) begin
                core_done = (run_cyc == done_at);
                core_dout = core_fn(core_din, core_key);
                run_cyc++;
            end else begin
                core_done = 1'b0;
                run_cyc = 0;
            end

            chk("in_ready",  in_ready,  m_phase == 0);
            chk("busy",      busy,      m_phase != 0);
            chk("out_valid", out_valid, m_phase == 2);
            chk("core_rst",  core_rst,  m_phase != 1);
            chk("err",       err,       m_err);
            if (m_phase == 1) begin
                chk("core_din", core_din, m_pt);
                chk("core_key", core_key, m_key);
            end
            if (m_phase == 2) chk("out_data", out_data, m_ct[127 - 8*m_nout -: 8]);
            if (prev_stall) chk("out_stable", out_data, prev_data);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;

            case (m_phase)
                0: if (in_valid) begin
                    if (m_nin < 16) m_pt = {m_pt[119:0], in_data};
                    else            m_key = {m_key[119:0], in_data};
                    m_nin++;
                    if (m_nin == 32) begin m_phase = 1; m_run = 0; end
                end
                1: begin
                    if (core_done) begin
                        m_ct = core_fn(m_pt, m_key); m_phase = 2; m_nout = 0;
                    end else if (m_run == MAXR - 1) begin
                        m_err = 1'b1; m_phase = 0; m_nin = 0;
                    end else begin
                        m_run++;
                    end
                end
                default: if (out_ready) begin
                    rx.push_back(out_data);
                    m_nout++;
                    if (m_nout == 16) begin m_phase = 0; m_nin = 0; end
                end
            endcase
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    task automatic send_bytes(input logic [255:0] blk, input int n, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            int budget = 4000;
            bit acc = 1'b0;
            in_data = blk[255 - 8*i -: 8];
            while (!acc) begin
                in_valid = ($urandom_range(99) >= gap_pct);
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                budget--;
                if (budget == 0) begin
                    timeout("send_byte");
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        while (rx.size() < n && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (rx.size() < n) timeout("wait_rx");
    endtask

    task automatic wait_idle();
        int budget = 3000;
        @(negedge clk);
        while ((busy || !in_ready) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) timeout("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic check_rx(input logic [127:0] exp, input string name);
        for (int i = 0; i < 16; i++) begin
            if (rx.size() == 0) begin
                timeout(name);
                return;
            end
            chk(name, rx.pop_front(), exp[127 - 8*i -: 8]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout t=%0t", $time);
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "global timeout");
    end

    initial begin
        logic [127:0] r_pts [3];
        logic [127:0] r_keys[3];
        int n;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_core_rst",  core_rst,  1'b1);
        chk("rst_core_din",  core_din,  '0);
        chk("rst_core_key",  core_key,  '0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data",  out_data,  8'h00);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_err",       err,       1'b0);
        rst = 1'b0;

        // FIPS-197 C.1
        send_bytes({C1_PT, C1_KEY}, 32, 0);
        wait_rx(16, 2000);
        check_rx(C1_CT, "c1_ct");
        wait_idle();

        // Appendix B then C.1, back to back
        send_bytes({B_PT, B_KEY}, 32, 0);
        send_bytes({C1_PT, C1_KEY}, 32, 0);
        wait_rx(32, 2000);
        check_rx(B_CT, "b_ct");
        check_rx(C1_CT, "c1_again_ct");
        wait_idle();

        // Random blocks with input gaps and output backpressure
        ready_pct = 50;
        for (int k = 0; k < 3; k++) begin
            r_pts[k]  = {$urandom, $urandom, $urandom, $urandom};
            r_keys[k] = {$urandom, $urandom, $urandom, $urandom};
            send_bytes({r_pts[k], r_keys[k]}, 32, 40);
        end
        wait_rx(48, 4000);
        for (int k = 0; k < 3; k++) check_rx(core_fn(r_pts[k], r_keys[k]), "rand_ct");
        wait_idle();

        // Done coincides with watchdog expiry
        ready_pct = 100;
        done_at = MAXR - 1;
        send_bytes({C1_PT, C1_KEY}, 32, 0);
        wait_rx(16, 3000);
        check_rx(C1_CT, "coinc_ct");
        chk("coinc_err", err, 1'b0);
        wait_idle();

        // Watchdog abort with a core that never finishes
        done_at = -1;
        send_bytes({B_PT, B_KEY}, 32, 0);
        n = 0;
        @(negedge clk);
        while (core_rst && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (!err && n < MAXR + 20) begin @(negedge clk); n++; end
        chk("wd_cycles",   n,         MAXR);
        chk("wd_err",      err,       1'b1);
        chk("wd_core_rst", core_rst,  1'b1);
        chk("wd_in_ready", in_ready,  1'b1);
        chk("wd_no_out",   rx.size(), 0);
        @(posedge clk); #1;

        // A new block is still served after an abort
        done_at = 55;
        send_bytes({C1_PT, C1_KEY}, 32, 0);
        wait_rx(16, 2000);
        check_rx(C1_CT, "post_abort_ct");
        chk("post_abort_err", err, 1'b1);
        wait_idle();

        // Reset after 20 input bytes discards the partial block
        send_bytes({B_PT, B_KEY}, 20, 0);
        rst = 1'b1;
        #1;
        chk("midrst_core_din", core_din, '0);
        chk("midrst_core_key", core_key, '0);
        chk("midrst_err",      err,      1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send_bytes({C1_PT, C1_KEY}, 32, 0);
        wait_rx(16, 2000);
        check_rx(C1_CT, "after_rst_ct");
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_byte_io.md
Name: aes_byte_io

Overview:
- Byte-serial front/back end for the iterative AES-128 encryption core. Sits directly upstream and downstream of the core.
- Collects 16 plaintext bytes, then 16 key bytes, from a valid/ready byte stream and presents them as 128-bit core_din/core_key.
- Releases the core from reset and waits for core_done. Then streams the 16 ciphertext bytes out on a second valid/ready byte stream.
- Includes a watchdog that aborts a hung encryption.

Parameters:
MAX_RUN_CYCLES, 1023, RUN-state cycles allowed before abort (must be >= 64; the core needs roughly 50–60 cycles).
CNT_W, 10, width of watchdog counter; must satisfy 2**CNT_W > MAX_RUN_CYCLES.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input byte valid
in_ready  out  1  block can accept input byte
in_data  in  8  input byte (plaintext bytes first, then key bytes)
out_valid  out  1  ciphertext byte valid
out_ready  in  1  sink accepts ciphertext byte
out_data  out  8  ciphertext byte
core_rst  out  1  registered reset to AES core, active-high
core_din  out  128  plaintext to core
core_key  out  128  key to core
core_dout  in  128  ciphertext from core
core_done  in  1  core completion flag
busy  out  1  high in RUN and UNLOAD
err  out  1  sticky watchdog abort flag

Behaviour:
- Reset values:
  - state LOAD_PT; byte counter 0; watchdog counter 0.
  - core_rst=1; core_din=0; core_key=0; output shift register 0.
  - in_ready=1 (combinational from state); out_valid=0; out_data=0; busy=0; err=0.
- Byte order: MSB first. The first accepted byte lands in bits [127:120]; the 16th lands in [7:0]. Loading is a left shift by 8 with the new byte inserted at [7:0]. The same order applies to ciphertext output.
- Input handshake: transfer occurs on a rising edge with in_valid && in_ready. in_ready=1 only in LOAD_PT and LOAD_KEY.
- LOAD_PT:
  - Each transfer shifts the byte into core_din and increments the 4-bit counter.
  - On the 16th transfer (counter 15): counter wraps to 0; next state LOAD_KEY.
- LOAD_KEY:
  - Same as LOAD_PT, but bytes go into core_key.
  - On the 16th transfer: next state RUN, and core_rst<=0 on the same edge. The core captures din/key on the following edge.
- RUN:
  - core_din and core_key are held stable.
  - The watchdog increments every cycle.
  - If core_done=1: capture core_dout into the output shift register; core_rst<=1; watchdog<=0; next state UNLOAD.
  - Otherwise, if watchdog==MAX_RUN_CYCLES-1: err<=1; core_rst<=1; watchdog<=0; next state LOAD_PT. No output is produced.
  - If core_done and watchdog expiry coincide, core_done wins.
- UNLOAD:
  - out_valid=1; out_data = shift register [127:120].
  - On out_valid && out_ready: shift left 8 and increment the counter.
  - On the 16th transfer: counter wraps to 0; next state LOAD_PT; out_valid drops next cycle.
  - out_data must stay stable while out_valid && !out_ready.
- err is cleared only by rst. A new block is accepted after an abort with err still 1.
- core_rst is 1 in every state except RUN. This guarantees the core restarts from its IDLE state for each block.
- in_valid in RUN or UNLOAD is ignored (in_ready=0); no bytes are dropped because none are accepted.
- Reset mid-operation: all registers return to reset values immediately. The core is held in reset, and partial plaintext/key is discarded.
- Throughput: 32 input cycles, plus core latency, plus 1 capture cycle, plus 16 output cycles (with sources and sinks always ready).

Decomposition:
- Package aes_io_pkg:
  - state encoding LOAD_PT/LOAD_KEY/RUN/UNLOAD (2 bits);
  - BLOCK_BYTES=16; byte counter width 4.
- Sub-module aes_byte_shreg: a 128-bit register with a parallel-load port and an 8-bit shift-in/shift-out port. Instantiated three times: plaintext, key and output.

Test Plan:
1. FIPS-197 C.1 vector.
   - Stimulus: stream 00112233445566778899aabbccddeeff, then key 000102030405060708090a0b0c0d0e0f, with out_ready=1.
   - Required response: out bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a; busy falls after the 16th byte.
2. FIPS-197 Appendix B vector, two blocks back to back.
   - Stimulus: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, then vector 1 again.
   - Required response: 3925841d02dc09fbdc118597196a0b32, followed by the C.1 ciphertext; core_rst pulses high between blocks.
3. Backpressure.
   - Stimulus: random in_valid gaps; out_ready toggled 50%.
   - Required response: identical ciphertext bytes; out_data stable while stalled; no duplicated or lost bytes.
4. Watchdog.
   - Stimulus: a core model that never asserts done.
   - Required response: exactly MAX_RUN_CYCLES cycles after entering RUN, err=1, core_rst=1, in_ready=1, and no out_valid.
5. Reset mid-operation.
   - Stimulus: rst after 20 input bytes, then a full vector 1.
   - Required response: correct 69c4…c55a output, proving the partial data was discarded.
6. Coincident done and expiry.
   - Stimulus: assert core_done in the watchdog expiry cycle.
   - Required response: UNLOAD entered; err stays 0.
